// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the alu_core execute-stage ALU.
//   ALU_OP_W        : width of the opcode field
//   ALU_ADD..ALU_NOP: opcode values. ALU_ROL and ALU_ROR are used only when
//                     ALU_ROTATE_EN is defined.
//   is_arith_op()   : true for the opcodes that report carry/overflow
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR   = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_PASSA = 4'd11;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd12;
    localparam logic [ALU_OP_W-1:0] ALU_ROL   = 4'd13;
    localparam logic [ALU_OP_W-1:0] ALU_ROR   = 4'd14;
    localparam logic [ALU_OP_W-1:0] ALU_NOP   = 4'd15;

    // Only ADD and SUB expose the adder's carry and overflow.
    // The compare ops use the adder internally but report both flags as 0.
    function automatic logic is_arith_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

    // The adder runs in subtract mode for SUB and for both compares.
    function automatic logic uses_subtract(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub
// Shared adder/subtractor for ADD, SUB, SLT and SLTU.
// When sub=1 it computes a + ~b + 1, so carry_out=1 means "no borrow".
// Ports:
//   a, b      : WIDTH-bit operands
//   sub       : 1 = subtract (invert b, carry-in 1), 0 = add
//   sum       : WIDTH-bit result
//   carry_out : bit WIDTH of the extended sum
//   overflow  : two's-complement overflow of the operation
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    // The carry-in is the same signal as sub, so one adder serves both directions.
    assign b_eff    = sub ? ~b : b;
    assign full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    assign sum       = full_sum[WIDTH-1:0];
    assign carry_out = full_sum[WIDTH];

    // Overflow occurs when both adder inputs have the same sign and the
    // result sign differs. This is checked against the inverted b for SUB.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (full_sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_core.sv
// alu_core
// Execute-stage integer ALU with a registered result and condition flags.
// The result and flags are available one clock after the operands are accepted.
// Optional feature macro: ALU_ROTATE_EN. When defined, op 13 is ROL and op 14 is ROR.
// When undefined, ops 13 and 14 return 0 like op 15.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : a, b and op are valid this cycle
//   a, b      : operands. For shifts and rotates, b[$clog2(WIDTH)-1:0] is the amount.
//   op        : opcode (see alu_pkg)
//   out_valid : y and flags hold the result of the op accepted last cycle
//   y         : registered result
//   carry     : carry (ADD) or no-borrow (SUB). 0 for all other ops.
//   overflow  : signed overflow for ADD/SUB. 0 for all other ops.
//   zero      : y == 0
//   negative  : y[WIDTH-1]
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] op,
    output logic                out_valid,
    output logic [WIDTH-1:0]    y,
    output logic                carry,
    output logic                overflow,
    output logic                zero,
    output logic                negative
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;
    logic             lt_signed;
    logic             lt_unsigned;

    logic [WIDTH-1:0] y_next;
    logic             carry_next;
    logic             overflow_next;

    // Using only the low bits of b makes every shift amount wrap modulo WIDTH.
    assign shamt = b[SHW-1:0];

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (uses_subtract(op)),
        .sum      (as_sum),
        .carry_out(as_carry),
        .overflow (as_overflow)
    );

    // After a - b, the signed less-than result is the difference's sign,
    // corrected by overflow. Unsigned less-than is a borrow, so no carry-out.
    assign lt_signed   = as_sum[WIDTH-1] ^ as_overflow;
    assign lt_unsigned = ~as_carry;

`ifdef ALU_ROTATE_EN
    logic [2*WIDTH-1:0] rot_left_wide;
    logic [2*WIDTH-1:0] rot_right_wide;

    // Shifting {a,a} yields the rotation in one half of the wide word.
    // This also handles a shift amount of 0 without a special case.
    assign rot_left_wide  = {a, a} << shamt;
    assign rot_right_wide = {a, a} >> shamt;
`endif

    // Result mux. Undefined opcodes fall to the default and produce zero.
    // This covers 13/14 when rotate is disabled.
    always_comb begin
        y_next = '0;
        case (op)
            ALU_ADD:   y_next = as_sum;
            ALU_SUB:   y_next = as_sum;
            ALU_AND:   y_next = a & b;
            ALU_OR:    y_next = a | b;
            ALU_XOR:   y_next = a ^ b;
            ALU_NOR:   y_next = ~(a | b);
            ALU_SLL:   y_next = a << shamt;
            ALU_SRL:   y_next = a >> shamt;
            ALU_SRA:   y_next = $unsigned($signed(a) >>> shamt);
            ALU_SLT:   y_next = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU:  y_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
            ALU_PASSA: y_next = a;
            ALU_PASSB: y_next = b;
`ifdef ALU_ROTATE_EN
            ALU_ROL:   y_next = rot_left_wide[2*WIDTH-1:WIDTH];
            ALU_ROR:   y_next = rot_right_wide[WIDTH-1:0];
`endif
            default:   y_next = '0;
        endcase
    end

    // Carry and overflow come from the adder, but only ADD and SUB report them.
    always_comb begin
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        if (is_arith_op(op)) begin
            carry_next    = as_carry;
            overflow_next = as_overflow;
        end
    end

    // Output register.
    // When no op is accepted, the previous result stays visible and only
    // out_valid drops. Reset takes priority over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            y         <= y_next;
            carry     <= carry_next;
            overflow  <= overflow_next;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // zero and negative come from the registered result.
    // After reset this makes zero read 1.
    assign zero     = (y == '0);
    assign negative = y[WIDTH-1];

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core
// Directed, table-driven bench for alu_core at WIDTH=32.
// Rotate expectations follow the ALU_ROTATE_EN macro.
module tb_alu_core;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic [W-1:0] y;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    int checks;
    int errors;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_y;
        logic         exp_c;
        logic         exp_v;
    } vec_t;

    vec_t vecs[$];

    alu_core #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .y        (y),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic [3:0] o,
                                input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [W-1:0] ey, input logic ec, input logic ev);
        vec_t v;
        v.name  = name;
        v.op    = o;
        v.a     = va;
        v.b     = vb;
        v.exp_y = ey;
        v.exp_c = ec;
        v.exp_v = ev;
        return v;
    endfunction

    task automatic checkField(input string name, input string field,
                              input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
        end
    endtask

    // Compares every output against the expected result.
    // The expected zero and negative values are derived from the expected y.
    task automatic checkOutput(input string name, input logic [W-1:0] ey,
                               input logic ec, input logic ev, input logic evalid);
        checkField(name, "y",         y,                    ey);
        checkField(name, "carry",     {31'b0, carry},       {31'b0, ec});
        checkField(name, "overflow",  {31'b0, overflow},    {31'b0, ev});
        checkField(name, "zero",      {31'b0, zero},        {31'b0, (ey == '0)});
        checkField(name, "negative",  {31'b0, negative},    {31'b0, ey[W-1]});
        checkField(name, "out_valid", {31'b0, out_valid},   {31'b0, evalid});
    endtask

    // Drives one cycle of inputs on the falling edge.
    // It then waits for the capturing rising edge and lets outputs settle.
    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] o,
                                 input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        op       = o;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 4'd0;
        a        = '0;
        b        = '0;

        vecs.push_back(mk("add_ovf",   4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1));
        vecs.push_back(mk("add_carry", 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0));
        vecs.push_back(mk("add_plain", 4'd0,  32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0));
        vecs.push_back(mk("sub_5_7",   4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0));
        vecs.push_back(mk("sub_0_1",   4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0));
        vecs.push_back(mk("sub_7_5",   4'd1,  32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0));
        vecs.push_back(mk("sub_ovf",   4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1));
        vecs.push_back(mk("and",       4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0));
        vecs.push_back(mk("and_ones",  4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0));
        vecs.push_back(mk("or",        4'd3,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0));
        vecs.push_back(mk("xor",       4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0));
        vecs.push_back(mk("nor_zero",  4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0));
        vecs.push_back(mk("nor_full",  4'd5,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b0));
        vecs.push_back(mk("sll_31",    4'd6,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0));
        vecs.push_back(mk("sll_0",     4'd6,  32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0));
        vecs.push_back(mk("sll_33",    4'd6,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0));
        vecs.push_back(mk("srl_4",     4'd7,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0));
        vecs.push_back(mk("srl_32",    4'd7,  32'h80000000, 32'h00000020, 32'h80000000, 1'b0, 1'b0));
        vecs.push_back(mk("sra_neg",   4'd8,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0));
        vecs.push_back(mk("sra_pos",   4'd8,  32'h40000000, 32'h00000004, 32'h04000000, 1'b0, 1'b0));
        vecs.push_back(mk("slt_m1_1",  4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0));
        vecs.push_back(mk("slt_1_m1",  4'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0));
        vecs.push_back(mk("slt_minmax",4'd9,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0));
        vecs.push_back(mk("sltu_big",  4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0));
        vecs.push_back(mk("sltu_small",4'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0));
        vecs.push_back(mk("passa",     4'd11, 32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF, 1'b0, 1'b0));
        vecs.push_back(mk("passb",     4'd12, 32'h00000001, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0));
        vecs.push_back(mk("op15",      4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0));
`ifdef ALU_ROTATE_EN
        vecs.push_back(mk("rol",       4'd13, 32'h80000001, 32'h00000001, 32'h00000003, 1'b0, 1'b0));
        vecs.push_back(mk("ror",       4'd14, 32'h80000001, 32'h00000001, 32'hC0000000, 1'b0, 1'b0));
`else
        vecs.push_back(mk("op13",      4'd13, 32'h80000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0));
        vecs.push_back(mk("op14",      4'd14, 32'h80000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0));
`endif

        // Reset state check.
        applyStimulus(1'b1, 1'b0, 4'd0, '0, '0);
        applyStimulus(1'b1, 1'b0, 4'd0, '0, '0);
        checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0);

        // First op after reset: ADD of zeros.
        applyStimulus(1'b0, 1'b1, 4'd0, 32'h0, 32'h0);
        checkOutput("smoke", 32'h0, 1'b0, 1'b0, 1'b1);

        // Table of vectors, one per cycle, applied back-to-back.
        foreach (vecs[i]) begin
            applyStimulus(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput(vecs[i].name, vecs[i].exp_y, vecs[i].exp_c, vecs[i].exp_v, 1'b1);
        end

        // Hold: a result with flags set, then an idle cycle with changed inputs.
        applyStimulus(1'b0, 1'b1, 4'd0, 32'hFFFFFFFF, 32'h00000002);
        checkOutput("hold_pre", 32'h00000001, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'd2, 32'h12345678, 32'h0);
        checkOutput("hold_idle", 32'h00000001, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd4, 32'hAAAAAAAA, 32'h55555555);
        checkOutput("hold_idle2", 32'h00000001, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream overrides a valid op in the same cycle.
        applyStimulus(1'b0, 1'b1, 4'd0, 32'h7FFFFFFF, 32'h00000001);
        checkOutput("pre_rst", 32'h80000000, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 4'd0, 32'hFFFFFFFF, 32'h00000001);
        checkOutput("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0);

        // Recovery after reset.
        applyStimulus(1'b0, 1'b1, 4'd1, 32'h00000000, 32'h00000001);
        checkOutput("post_rst", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
